// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, writeback port, issue port and status.
// Ports: master drives addresses, writeback and issue; slave returns read data,
//        busy/hazard flags, pending count and the sticky WAW error.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              hazard;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W:0]   pend_cnt;
  logic              err;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, hazard, pend_cnt, err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, hazard, pend_cnt, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, write bypass and WAW error detect.
// Latency: reads/busy are combinational (writeback bypassed); state updates on the clk rise.
// No backpressure: every issue and writeback is accepted in the cycle it is presented.
// Ports: clk, reset (async active-high), bus (slave modport of regfile_scoreboard_if).
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [ADDR_W:0]   r_pend_cnt;
  logic              r_err;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_same;
  logic              w_inc;
  logic              w_dec;
  logic              w_waw;
  logic [NREG-1:0]   w_busy_nxt;
  logic [DATA_W-1:0] w_rd_data_a;
  logic [DATA_W-1:0] w_rd_data_b;
  logic              w_busy_a;
  logic              w_busy_b;

  // Writes/issues to r0 are dropped when it is hardwired; everything is dropped in reset.
  assign w_wr_ok  = bus.wr_en  && !reset && !(ZR && bus.wr_addr  == '0);
  assign w_iss_ok = bus.iss_en && !reset && !(ZR && bus.iss_addr == '0);
  assign w_same   = w_wr_ok && w_iss_ok && (bus.wr_addr == bus.iss_addr);

  // Counter deltas: an issue onto a same-cycle writeback target re-arms the bit,
  // so that writeback does not count as a release.
  assign w_inc = w_iss_ok && !r_busy[bus.iss_addr];
  assign w_dec = w_wr_ok && r_busy[bus.wr_addr] && !w_same;
  // Second producer for a register whose first result has not come back.
  assign w_waw = w_iss_ok && r_busy[bus.iss_addr] && !w_same;

  // Clear then set, so a same-cycle issue (new producer) wins over the writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[bus.wr_addr]  = 1'b0;
    if (w_iss_ok) w_busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_pend_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[bus.wr_addr] <= bus.wr_data;
      r_busy <= w_busy_nxt;
      if (w_inc && !w_dec)      r_pend_cnt <= r_pend_cnt + CNT_ONE;
      else if (w_dec && !w_inc) r_pend_cnt <= r_pend_cnt - CNT_ONE;
      if (w_waw) r_err <= 1'b1;
    end
  end

  // Read ports: hardwired zero beats bypass, bypass beats the stored value.
  always_comb begin
    w_rd_data_a = r_regs[bus.rd_addr_a];
    if (w_wr_ok && bus.wr_addr == bus.rd_addr_a) w_rd_data_a = bus.wr_data;
    if (ZR && bus.rd_addr_a == '0)               w_rd_data_a = '0;
    w_rd_data_b = r_regs[bus.rd_addr_b];
    if (w_wr_ok && bus.wr_addr == bus.rd_addr_b) w_rd_data_b = bus.wr_data;
    if (ZR && bus.rd_addr_b == '0)               w_rd_data_b = '0;
  end

  // A writeback in flight this cycle releases the hazard without waiting for the edge.
  assign w_busy_a = r_busy[bus.rd_addr_a] && !(bus.wr_en && bus.wr_addr == bus.rd_addr_a)
                    && !(ZR && bus.rd_addr_a == '0);
  assign w_busy_b = r_busy[bus.rd_addr_b] && !(bus.wr_en && bus.wr_addr == bus.rd_addr_b)
                    && !(ZR && bus.rd_addr_b == '0);

  assign bus.rd_data_a = w_rd_data_a;
  assign bus.rd_data_b = w_rd_data_b;
  assign bus.busy_a    = w_busy_a;
  assign bus.busy_b    = w_busy_b;
  assign bus.hazard    = w_busy_a || w_busy_b;
  assign bus.pend_cnt  = r_pend_cnt;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: a 32x32 build with hardwired r0 and an 8x8 build
// where r0 is an ordinary register, driven from vector tables, hand sequences and random
// traffic compared against an array-based reference model.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  regfile_scoreboard_if #(.DATA_W(8),  .ADDR_W(3)) ifb ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    logic        iss; int ia;
    logic        wr;  int wa; logic [31:0] wd;
    int          ra;  int rb;
  } in_t;

  typedef struct {
    logic [31:0] rd_a; logic [31:0] rd_b;
    logic busy_a; logic busy_b; logic hazard;
    logic [31:0] cnt; logic err;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed [dut][register].
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  bit          m_err  [2];
  int          m_n    [2] = '{32, 8};
  bit          m_zr   [2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input out_t a, input out_t e);
    chk({tag, ".rd_a"},   a.rd_a, e.rd_a);
    chk({tag, ".rd_b"},   a.rd_b, e.rd_b);
    chk({tag, ".busy_a"}, 32'(a.busy_a), 32'(e.busy_a));
    chk({tag, ".busy_b"}, 32'(a.busy_b), 32'(e.busy_b));
    chk({tag, ".hazard"}, 32'(a.hazard), 32'(e.hazard));
    chk({tag, ".cnt"},    a.cnt, e.cnt);
    chk({tag, ".err"},    32'(a.err), 32'(e.err));
  endtask

  function automatic in_t idle();
    in_t v;
    v.iss = 0; v.ia = 0; v.wr = 0; v.wa = 0; v.wd = 0; v.ra = 0; v.rb = 0;
    return v;
  endfunction

  function automatic in_t mk_in(logic iss, int ia, logic wr, int wa, logic [31:0] wd, int ra, int rb);
    in_t v;
    v.iss = iss; v.ia = ia; v.wr = wr; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    return v;
  endfunction

  function automatic out_t mk_out(logic [31:0] ra, logic [31:0] rb, logic ba, logic bb,
                                  logic hz, int cnt, logic e);
    out_t o;
    o.rd_a = ra; o.rd_b = rb; o.busy_a = ba; o.busy_b = bb; o.hazard = hz;
    o.cnt = cnt; o.err = e;
    return o;
  endfunction

  task automatic drive_a(input in_t v);
    ifa.iss_en = v.iss; ifa.iss_addr = v.ia[4:0];
    ifa.wr_en = v.wr; ifa.wr_addr = v.wa[4:0]; ifa.wr_data = v.wd;
    ifa.rd_addr_a = v.ra[4:0]; ifa.rd_addr_b = v.rb[4:0];
  endtask

  task automatic drive_b(input in_t v);
    ifb.iss_en = v.iss; ifb.iss_addr = v.ia[2:0];
    ifb.wr_en = v.wr; ifb.wr_addr = v.wa[2:0]; ifb.wr_data = v.wd[7:0];
    ifb.rd_addr_a = v.ra[2:0]; ifb.rd_addr_b = v.rb[2:0];
  endtask

  function automatic out_t sample_a();
    out_t o;
    o.rd_a = ifa.rd_data_a; o.rd_b = ifa.rd_data_b;
    o.busy_a = ifa.busy_a; o.busy_b = ifa.busy_b; o.hazard = ifa.hazard;
    o.cnt = {26'd0, ifa.pend_cnt}; o.err = ifa.err;
    return o;
  endfunction

  function automatic out_t sample_b();
    out_t o;
    o.rd_a = {24'd0, ifb.rd_data_a}; o.rd_b = {24'd0, ifb.rd_data_b};
    o.busy_a = ifb.busy_a; o.busy_b = ifb.busy_b; o.hazard = ifb.hazard;
    o.cnt = {28'd0, ifb.pend_cnt}; o.err = ifb.err;
    return o;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 0;
      for (int k = 0; k < 32; k++) begin m_reg[d][k] = 0; m_busy[d][k] = 0; end
    end
  endtask

  function automatic logic [31:0] m_read(int d, in_t v, int addr);
    bit wok = v.wr && !(m_zr[d] && v.wa == 0);
    if (m_zr[d] && addr == 0) return 0;
    if (wok && v.wa == addr) return v.wd;
    return m_reg[d][addr];
  endfunction

  function automatic logic m_bsy(int d, in_t v, int addr);
    if (m_zr[d] && addr == 0) return 0;
    return m_busy[d][addr] && !(v.wr && v.wa == addr);
  endfunction

  function automatic out_t m_pred(int d, in_t v);
    out_t o;
    int n = 0;
    for (int k = 0; k < m_n[d]; k++) n += int'(m_busy[d][k]);
    o.rd_a = m_read(d, v, v.ra); o.rd_b = m_read(d, v, v.rb);
    o.busy_a = m_bsy(d, v, v.ra); o.busy_b = m_bsy(d, v, v.rb);
    o.hazard = o.busy_a || o.busy_b;
    o.cnt = n; o.err = m_err[d];
    return o;
  endfunction

  task automatic m_step(int d, in_t v);
    bit wok, iok, old;
    wok = v.wr  && !(m_zr[d] && v.wa == 0);
    iok = v.iss && !(m_zr[d] && v.ia == 0);
    old = m_busy[d][v.ia];
    if (wok) begin m_reg[d][v.wa] = v.wd; m_busy[d][v.wa] = 0; end
    if (iok) begin
      if (old && !(wok && v.wa == v.ia)) m_err[d] = 1;
      m_busy[d][v.ia] = 1;
    end
  endtask

  // Addresses cluster on a few registers most of the time so busy/WAW cases occur often.
  function automatic int pick(int n);
    if ($urandom_range(0, 3) != 0) return $urandom_range(0, 5 < n - 1 ? 5 : n - 1);
    return $urandom_range(0, n - 1);
  endfunction

  function automatic in_t gen(int n, logic [31:0] mask);
    in_t v;
    v.iss = ($urandom_range(0, 2) == 0);
    v.ia  = pick(n);
    v.wr  = ($urandom_range(0, 1) == 1);
    v.wa  = pick(n);
    v.wd  = $urandom & mask;
    v.ra  = pick(n);
    v.rb  = pick(n);
    return v;
  endfunction

  vec_t tbl [14];
  in_t  va, vb;

  initial begin
    tbl[0]  = '{mk_in(0,0,0,0,0,3,0),        mk_out(0,0,0,0,0,0,0)};
    tbl[1]  = '{mk_in(1,3,0,0,0,3,0),        mk_out(0,0,0,0,0,0,0)};
    tbl[2]  = '{mk_in(0,0,0,0,0,3,0),        mk_out(0,0,1,0,1,1,0)};
    tbl[3]  = '{mk_in(0,0,1,3,32'h1234,3,0), mk_out(32'h1234,0,0,0,0,1,0)};
    tbl[4]  = '{mk_in(0,0,0,0,0,3,0),        mk_out(32'h1234,0,0,0,0,0,0)};
    tbl[5]  = '{mk_in(1,5,1,5,7,5,0),        mk_out(7,0,0,0,0,0,0)};
    tbl[6]  = '{mk_in(0,0,0,0,0,5,0),        mk_out(7,0,1,0,1,1,0)};
    tbl[7]  = '{mk_in(1,4,0,0,0,4,0),        mk_out(0,0,0,0,0,1,0)};
    tbl[8]  = '{mk_in(1,4,0,0,0,4,0),        mk_out(0,0,1,0,1,2,0)};
    tbl[9]  = '{mk_in(0,0,0,0,0,4,0),        mk_out(0,0,1,0,1,2,1)};
    tbl[10] = '{mk_in(1,0,1,0,32'hFFFF,0,0), mk_out(0,0,0,0,0,2,1)};
    tbl[11] = '{mk_in(0,0,0,0,0,0,0),        mk_out(0,0,0,0,0,2,1)};
    tbl[12] = '{mk_in(0,0,1,4,32'hAB,4,5),   mk_out(32'hAB,7,0,1,1,2,1)};
    tbl[13] = '{mk_in(0,0,0,0,0,4,3),        mk_out(32'hAB,32'h1234,0,0,0,1,1)};

    reset = 1'b1;
    drive_a(idle()); drive_b(idle());
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Post-reset sweep of every address on both builds.
    for (int a = 0; a < 32; a++) begin
      drive_a(mk_in(0,0,0,0,0,a,31-a));
      if (a < 8) drive_b(mk_in(0,0,0,0,0,a,7-a));
      #1;
      cmp($sformatf("rst_a%0d", a), sample_a(), mk_out(0,0,0,0,0,0,0));
      if (a < 8) cmp($sformatf("rst_b%0d", a), sample_b(), mk_out(0,0,0,0,0,0,0));
    end
    drive_a(idle()); drive_b(idle());
    @(posedge clk); #1;

    // Vector table on the hardwired-r0 build.
    for (int i = 0; i < 14; i++) begin
      drive_a(tbl[i].i); #2;
      cmp($sformatf("vec%0d", i), sample_a(), tbl[i].o);
      @(posedge clk); #1;
    end
    drive_a(idle());

    // r0 is an ordinary register in the second build.
    drive_b(mk_in(1,0,0,0,0,0,0)); #2;
    chk("b_r0_busy_pre", 32'(ifb.busy_a), 0);
    @(posedge clk); #1;
    drive_b(mk_in(0,0,0,0,0,0,0)); #2;
    chk("b_r0_busy", 32'(ifb.busy_a), 1);
    chk("b_r0_cnt", {28'd0, ifb.pend_cnt}, 1);
    @(posedge clk); #1;
    drive_b(mk_in(0,0,1,0,32'h5A,0,0)); #2;
    chk("b_r0_byp", {24'd0, ifb.rd_data_a}, 32'h5A);
    chk("b_r0_rel", 32'(ifb.busy_a), 0);
    @(posedge clk); #1;
    drive_b(idle()); #2;
    chk("b_r0_data", {24'd0, ifb.rd_data_a}, 32'h5A);
    chk("b_r0_cnt0", {28'd0, ifb.pend_cnt}, 0);
    @(posedge clk); #1;

    // Issue (and write) every register, then reset between edges.
    for (int a = 0; a < 32; a++) begin
      drive_a(mk_in(1,a,1,a,a+100,0,0));
      if (a < 8) drive_b(mk_in(1,a,1,a,a+100,0,0)); else drive_b(idle());
      @(posedge clk); #1;
    end
    drive_a(mk_in(0,0,0,0,0,7,20)); drive_b(mk_in(0,0,0,0,0,7,0)); #2;
    chk("full_a_cnt", {26'd0, ifa.pend_cnt}, 31);
    chk("full_b_cnt", {28'd0, ifb.pend_cnt}, 8);
    chk("full_a_rd", ifa.rd_data_a, 107);
    chk("full_a_busy", 32'(ifa.busy_a), 1);
    chk("full_b_rd", {24'd0, ifb.rd_data_a}, 107);
    reset = 1'b1; #1;
    chk("arst_a_cnt", {26'd0, ifa.pend_cnt}, 0);
    chk("arst_a_err", 32'(ifa.err), 0);
    chk("arst_a_rd", ifa.rd_data_a, 0);
    chk("arst_a_rdb", ifa.rd_data_b, 0);
    chk("arst_a_busy", 32'(ifa.hazard), 0);
    chk("arst_b_cnt", {28'd0, ifb.pend_cnt}, 0);
    chk("arst_b_rd", {24'd0, ifb.rd_data_a}, 0);
    chk("arst_b_busy", 32'(ifb.busy_a), 0);

    // Writes and issues presented during reset leave no trace.
    drive_a(mk_in(1,7,1,7,32'h55,7,0)); drive_b(mk_in(1,7,1,7,32'h55,7,0));
    @(posedge clk); #1;
    drive_a(mk_in(0,0,0,0,0,7,0)); drive_b(mk_in(0,0,0,0,0,7,0));
    #1 reset = 1'b0; #1;
    chk("inrst_a_rd", ifa.rd_data_a, 0);
    chk("inrst_a_cnt", {26'd0, ifa.pend_cnt}, 0);
    chk("inrst_b_rd", {24'd0, ifb.rd_data_a}, 0);
    chk("inrst_b_busy", 32'(ifb.busy_a), 0);
    @(posedge clk); #1;

    // Random traffic against the reference model, with a reset between blocks.
    m_reset();
    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 150; c++) begin
        va = gen(32, 32'hFFFF_FFFF);
        vb = gen(8, 32'h0000_00FF);
        drive_a(va); drive_b(vb); #2;
        cmp($sformatf("rnd_a%0d_%0d", blk, c), sample_a(), m_pred(0, va));
        cmp($sformatf("rnd_b%0d_%0d", blk, c), sample_b(), m_pred(1, vb));
        m_step(0, va); m_step(1, vb);
        @(posedge clk); #1;
      end
      drive_a(idle()); drive_b(idle());
      reset = 1'b1; #2 reset = 1'b0;
      m_reset();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
